// File: rtl/fast_square.sv
// fast_square
//   Signed 9-bit squarer with one registered output stage. The magnitude of
//   the operand is squared as a folded partial-product array. The array is
//   reduced by a carry-save tree of full adders to two rows, and those two
//   rows are added by a single 18-bit carry-propagate adder.
//
// Ports
//   clk    in   1   rising-edge clock
//   rstb   in   1   asynchronous active-low reset, clears sqr_a
//   a      in   9   signed two's-complement operand, -256..255
//   sqr_a  out  18  unsigned a*a, registered (1 cycle latency); bit 17 is always 0
module fast_square (
    input  logic              clk,
    input  logic              rstb,
    input  logic signed [8:0] a,
    output logic [17:0]       sqr_a
);

    localparam int W = 18;  // column weights 0..17
    localparam int H = 6;   // tallest initial column is 5 bits; 6 keeps stage heights regular

    // Bit matrix: one entry per column weight, each column up to H bits deep.
    // Unused slots are held at zero and fold away in synthesis.
    typedef logic [W-1:0][H-1:0] mat_t;

    // Place the diagonal bits (m_i at weight 2i) and the 36 cross terms
    // (m_i & m_j at weight i+j+1, the doubling folded into the shift).
    function automatic mat_t build_pp(input logic [8:0] m);
        mat_t pp;
        int   cnt [W];
        pp = '0;
        for (int c = 0; c < W; c++) cnt[c] = 0;
        for (int i = 0; i < 9; i++) begin
            pp[2*i][cnt[2*i]] = m[i];
            cnt[2*i]++;
        end
        for (int i = 0; i < 9; i++) begin
            for (int j = i + 1; j < 9; j++) begin
                pp[i+j+1][cnt[i+j+1]] = m[i] & m[j];
                cnt[i+j+1]++;
            end
        end
        return pp;
    endfunction

    // One carry-save layer. Every column of height hin is cut into groups of
    // three bits. Each group becomes a sum bit in the same column and a carry
    // bit in the next column. Leftover bits pass straight through. Output
    // height is 2*(hin/3) + hin%3, which gives 6 -> 4 -> 3 -> 2.
    // A carry out of column 17 is dropped because the square never exceeds 2^16.
    function automatic mat_t csa_stage(input mat_t x, input int hin);
        mat_t y;
        int   pos;
        int   ng;
        y  = '0;
        ng = hin / 3;
        for (int c = 0; c < W; c++) begin
            pos = 0;
            if (c > 0) begin
                for (int g = 0; g < ng; g++) begin
                    y[c][pos] = (x[c-1][3*g] & x[c-1][3*g+1]) |
                                (x[c-1][3*g] & x[c-1][3*g+2]) |
                                (x[c-1][3*g+1] & x[c-1][3*g+2]);
                    pos++;
                end
            end
            for (int g = 0; g < ng; g++) begin
                y[c][pos] = x[c][3*g] ^ x[c][3*g+1] ^ x[c][3*g+2];
                pos++;
            end
            for (int r = ng * 3; r < hin; r++) begin
                y[c][pos] = x[c][r];
                pos++;
            end
        end
        return y;
    endfunction

    logic [8:0]  a_u;
    logic [8:0]  mag;
    mat_t        pp0;
    mat_t        pp1;
    mat_t        pp2;
    mat_t        pp3;
    logic [17:0] row0;
    logic [17:0] row1;
    logic [17:0] sqr_a_d;
    logic [17:0] sqr_a_q;

    always_comb begin
        a_u = a;
        // Invert-plus-one gated by the sign bit. -256 becomes 256 (bit 8 set),
        // which is the correct magnitude and not an overflow.
        mag = a_u[8] ? (~a_u + 9'd1) : a_u;

        pp0 = build_pp(mag);
        pp1 = csa_stage(pp0, 6);
        pp2 = csa_stage(pp1, 4);
        pp3 = csa_stage(pp2, 3);

        row0 = '0;
        row1 = '0;
        for (int c = 0; c < W; c++) begin
            row0[c] = pp3[c][0];
            row1[c] = pp3[c][1];
        end
        sqr_a_d = row0 + row1;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) sqr_a_q <= '0;
        else       sqr_a_q <= sqr_a_d;
    end

    assign sqr_a = sqr_a_q;

endmodule

// File: tb/tb_fast_square.sv
// tb_fast_square
//   Self-checking bench for fast_square. The stimulus drives a on the falling
//   edge. The expected square comes from a plain-arithmetic reference model
//   and goes into exp_q. The output is sampled 1 ns after the rising edge.
module tb_fast_square;

    logic              clk;
    logic              rstb;
    logic signed [8:0] a;
    logic [17:0]       sqr_a;

    logic [17:0] exp_q[$];
    int          n_cmp;
    int          n_bad;
    logic [17:0] last_exp;

    fast_square dut (
        .clk   (clk),
        .rstb  (rstb),
        .a     (a),
        .sqr_a (sqr_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the square of the signed integer value of a.
    function automatic logic [17:0] ref_sq(input int v);
        int s;
        s = v * v;
        return s[17:0];
    endfunction

    task automatic check_val(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%05h) expected %0d (0x%05h)", tag, got, got, exp, exp);
        end
    endtask

    // Present one operand and check its square one edge later. When
    // check_hold is set, also check that the previous result is still
    // present after a changes and before the capturing edge.
    task automatic apply(input int v, input string tag, input bit check_hold);
        @(negedge clk);
        a = 9'(v);
        exp_q.push_back(ref_sq(v));
        if (check_hold) begin
            #1;
            check_val({tag, "_hold"}, sqr_a, last_exp);
        end
        @(posedge clk);
        #1;
        last_exp = exp_q.pop_front();
        check_val(tag, sqr_a, last_exp);
    endtask

    initial begin
        int v;
        n_cmp    = 0;
        n_bad    = 0;
        last_exp = '0;

        // Reset: the output is cleared before any clock edge has occurred.
        rstb = 1'b0;
        a    = 9'sd37;
        #2;
        check_val("reset_async", sqr_a, 18'd0);
        @(negedge clk);
        check_val("reset_hold", sqr_a, 18'd0);
        rstb = 1'b1;
        exp_q.push_back(ref_sq(37));
        @(posedge clk);
        #1;
        last_exp = exp_q.pop_front();
        check_val("reset_release", sqr_a, last_exp);
        check_val("reset_release_const", sqr_a, 18'd1369);

        // Exhaustive positive sweep.
        for (int i = 0; i <= 255; i++) apply(i, "pos_sweep", 1'b0);

        // Exhaustive negative sweep.
        for (int i = -1; i >= -256; i--) apply(i, "neg_sweep", 1'b0);
        check_val("neg256_const", sqr_a, 18'h10000);
        check_val("neg256_bit17", {17'd0, sqr_a[17]}, 18'd0);

        // Symmetry, back-to-back, with the previous result checked until the edge.
        apply(127,  "sym", 1'b1);
        check_val("sym_127", sqr_a, 18'd16129);
        apply(-127, "sym", 1'b1);
        check_val("sym_m127", sqr_a, 18'd16129);
        apply(128,  "sym", 1'b1);
        check_val("sym_128", sqr_a, 18'd16384);
        apply(-128, "sym", 1'b1);
        check_val("sym_m128", sqr_a, 18'd16384);

        // Reset mid-stream: the result for 202 is discarded.
        apply(200, "mid", 1'b0);
        apply(201, "mid", 1'b0);
        @(negedge clk);
        a = 9'sd202;
        #1;
        rstb = 1'b0;
        #1;
        check_val("mid_async_clear", sqr_a, 18'd0);
        @(posedge clk);
        #1;
        check_val("mid_held_clear", sqr_a, 18'd0);
        @(negedge clk);
        rstb = 1'b1;
        a    = 9'sd3;
        #1;
        check_val("mid_no_stale", sqr_a, 18'd0);
        @(posedge clk);
        #1;
        check_val("mid_after_release", sqr_a, ref_sq(3));
        last_exp = ref_sq(3);

        // Hold: a constant operand gives a steady output.
        for (int i = 0; i < 10; i++) apply(-77, "hold_m77", 1'b1);
        check_val("hold_m77_const", sqr_a, 18'd5929);

        // Random operands over the full range.
        for (int i = 0; i < 300; i++) begin
            v = int'($urandom_range(0, 511));
            if (v > 255) v = v - 512;
            apply(v, "random", (i % 4) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
